// File: rtl/pulse_gen_pkg.sv
// Shared state encoding and default widths for the pulse-train generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        DONE
    } pg_state_e;

    localparam int PG_MSB   = 4;
    localparam int PG_DEPTH = 3;

endpackage

// File: rtl/pulse_gen_cnt.sv
// Loadable phase-length down-counter; saturates at 1 so it never wraps.
module pulse_gen_cnt
    import pulse_gen_pkg::*;
#(
    parameter int MSB = PG_MSB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [MSB:0] load_val,
    input  logic         en,
    output logic         last
);

    localparam int W = MSB + 1;

    logic [MSB:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q > W'(1))) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == W'(1));

endmodule

// File: rtl/pulse_gen.sv
// Burst pulse-train generator: start latches lengths and count, the FSM
// walks HIGH/LOW phases and ends with a one-cycle DONE strobe.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int MSB   = PG_MSB,
    parameter int depth = PG_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [MSB:0]     hi_len,
    input  logic [MSB:0]     lo_len,
    input  logic [depth-1:0] num,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [depth-1:0] pulse_cnt
);

    localparam int W = MSB + 1;

    pg_state_e        state_q, state_d;
    logic [MSB:0]     hiLen_q, hiLen_d;
    logic [MSB:0]     loLen_q, loLen_d;
    logic [depth-1:0] num_q, num_d;
    logic [depth-1:0] pulseCnt_q, pulseCnt_d;
    logic [depth-1:0] cntInc;
    logic [MSB:0]     hiLenIn, loLenIn;
    logic             cntLoad;
    logic [MSB:0]     cntLoadVal;
    logic             cntEn;
    logic             cntLast;

    // A requested length of zero still produces a one-cycle phase.
    assign hiLenIn = (hi_len == '0) ? W'(1) : hi_len;
    assign loLenIn = (lo_len == '0) ? W'(1) : lo_len;
    assign cntInc  = pulseCnt_q + depth'(1);

    pulse_gen_cnt #(
        .MSB(MSB)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cntLoad),
        .load_val(cntLoadVal),
        .en      (cntEn),
        .last    (cntLast)
    );

    always_comb begin
        state_d    = state_q;
        hiLen_d    = hiLen_q;
        loLen_d    = loLen_q;
        num_d      = num_q;
        pulseCnt_d = pulseCnt_q;
        cntLoad    = 1'b0;
        cntLoadVal = '0;
        cntEn      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    hiLen_d    = hiLenIn;
                    loLen_d    = loLenIn;
                    num_d      = num;
                    pulseCnt_d = '0;
                    if (num == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = HIGH;
                        cntLoad    = 1'b1;
                        cntLoadVal = hiLenIn;
                    end
                end
            end
            HIGH: begin
                cntEn = 1'b1;
                // An aborted high phase is not counted, even on its last cycle.
                if (stop) begin
                    state_d = DONE;
                end else if (cntLast) begin
                    pulseCnt_d = cntInc;
                    if (cntInc == num_q) begin
                        state_d = DONE;
                    end else begin
                        state_d    = LOW;
                        cntLoad    = 1'b1;
                        cntLoadVal = loLen_q;
                    end
                end
            end
            LOW: begin
                cntEn = 1'b1;
                if (stop) begin
                    state_d = DONE;
                end else if (cntLast) begin
                    state_d    = HIGH;
                    cntLoad    = 1'b1;
                    cntLoadVal = hiLen_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hiLen_q    <= '0;
            loLen_q    <= '0;
            num_q      <= '0;
            pulseCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hiLen_q    <= hiLen_d;
            loLen_q    <= loLen_d;
            num_q      <= num_d;
            pulseCnt_q <= pulseCnt_d;
        end
    end

    assign pulse     = (state_q == HIGH);
    assign busy      = (state_q == HIGH) || (state_q == LOW);
    assign done      = (state_q == DONE);
    assign pulse_cnt = pulseCnt_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: a vector table of bursts checked cycle by
// cycle, plus hand sequences for stop, reset, ignored start and wide params.
module tb_pulse_gen;

    typedef struct {
        int hi;
        int lo;
        int num;
        int doneAt;
        int expCnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [4:0] hiLen;
    logic [4:0] loLen;
    logic [2:0] numIn;
    logic       pulse;
    logic       busy;
    logic       done;
    logic [2:0] pulseCnt;

    logic       start2;
    logic       stop2;
    logic [5:0] hiLen2;
    logic [5:0] loLen2;
    logic [3:0] numIn2;
    logic       pulse2;
    logic       busy2;
    logic       done2;
    logic [3:0] pulseCnt2;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    pulse_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .hi_len   (hiLen),
        .lo_len   (loLen),
        .num      (numIn),
        .pulse    (pulse),
        .busy     (busy),
        .done     (done),
        .pulse_cnt(pulseCnt)
    );

    pulse_gen #(
        .MSB  (5),
        .depth(4)
    ) dutWide (
        .clk      (clk),
        .rst      (rst),
        .start    (start2),
        .stop     (stop2),
        .hi_len   (hiLen2),
        .lo_len   (loLen2),
        .num      (numIn2),
        .pulse    (pulse2),
        .busy     (busy2),
        .done     (done2),
        .pulse_cnt(pulseCnt2)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int hi, input int lo, input int n);
        hiLen = hi[4:0];
        loLen = lo[4:0];
        numIn = n[2:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Starts a burst and compares every cycle against the ideal waveform.
    // reA/reB are relative cycles during which start is re-asserted.
    task automatic runVector(input string tag, input vec_t v, input int reA, input int reB,
                             input bit scramble);
        int  h;
        int  l;
        int  waveErrs;
        logic expP;
        applyStimulus(v.hi, v.lo, v.num);
        h        = (v.hi == 0) ? 1 : v.hi;
        l        = (v.lo == 0) ? 1 : v.lo;
        waveErrs = 0;
        for (int k = 1; k < v.doneAt; k++) begin
            expP = (((k - 1) % (h + l)) < h);
            if (pulse !== expP || busy !== 1'b1 || done !== 1'b0) waveErrs++;
            if (k == reA || k == reB) start = 1'b1;
            if (scramble) begin
                hiLen = 5'd31;
                loLen = 5'd31;
                numIn = 3'd7;
            end
            tick();
            start = 1'b0;
        end
        checkOutput({tag, " wave"}, waveErrs, 0);
        checkOutput({tag, " done"}, int'(done), 1);
        checkOutput({tag, " busy@done"}, int'(busy), 0);
        checkOutput({tag, " pulse@done"}, int'(pulse), 0);
        checkOutput({tag, " cnt"}, int'(pulseCnt), v.expCnt);
        if (v.doneAt == reA || v.doneAt == reB) start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput({tag, " idle done"}, int'(done), 0);
        checkOutput({tag, " idle busy"}, int'(busy), 0);
        checkOutput({tag, " cnt hold"}, int'(pulseCnt), v.expCnt);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t base;
        int   doneSeen;
        int   highs;
        int   doneCyc;

        vecs[0] = '{hi: 2,  lo: 3,  num: 3, doneAt: 13,  expCnt: 3};
        vecs[1] = '{hi: 0,  lo: 0,  num: 0, doneAt: 1,   expCnt: 0};
        vecs[2] = '{hi: 0,  lo: 0,  num: 2, doneAt: 4,   expCnt: 2};
        vecs[3] = '{hi: 1,  lo: 1,  num: 1, doneAt: 2,   expCnt: 1};
        vecs[4] = '{hi: 31, lo: 31, num: 7, doneAt: 404, expCnt: 7};
        vecs[5] = '{hi: 5,  lo: 0,  num: 4, doneAt: 24,  expCnt: 4};
        vecs[6] = '{hi: 3,  lo: 7,  num: 0, doneAt: 1,   expCnt: 0};
        base    = vecs[0];

        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        hiLen  = '0;
        loLen  = '0;
        numIn  = '0;
        start2 = 1'b0;
        stop2  = 1'b0;
        hiLen2 = '0;
        loLen2 = '0;
        numIn2 = '0;
        tick();
        tick();
        checkOutput("reset pulse", int'(pulse), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset cnt", int'(pulseCnt), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i], -1, -1, 1'b0);
            tick();
        end

        // Re-asserted start mid-burst and during DONE, plus changing inputs.
        runVector("restart", base, 2, 13, 1'b1);
        hiLen = 5'd2;
        loLen = 5'd3;
        numIn = 3'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restart accept pulse", int'(pulse), 1);
        checkOutput("restart accept cnt", int'(pulseCnt), 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        // Abort in the last cycle of the second high phase.
        applyStimulus(2, 3, 3);
        for (int k = 1; k < 7; k++) tick();
        checkOutput("stop pre pulse", int'(pulse), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop pulse", int'(pulse), 0);
        checkOutput("stop busy", int'(busy), 0);
        checkOutput("stop done", int'(done), 1);
        checkOutput("stop cnt", int'(pulseCnt), 1);
        tick();
        checkOutput("stop idle done", int'(done), 0);
        checkOutput("stop idle cnt", int'(pulseCnt), 1);

        // stop in IDLE is ignored; start with stop in IDLE is accepted.
        stop = 1'b1;
        tick();
        checkOutput("idle stop done", int'(done), 0);
        hiLen = 5'd2;
        loLen = 5'd2;
        numIn = 3'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start wins pulse", int'(pulse), 1);
        checkOutput("start wins busy", int'(busy), 1);
        tick();
        checkOutput("first high abort done", int'(done), 1);
        checkOutput("first high abort cnt", int'(pulseCnt), 0);
        stop = 1'b0;
        tick();

        // Stop coinciding with the natural end yields one DONE only.
        applyStimulus(1, 1, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop+end done", int'(done), 1);
        tick();
        checkOutput("stop+end single", int'(done), 0);
        checkOutput("stop+end busy", int'(busy), 0);
        tick();

        // Reset mid-burst while in the first low phase.
        applyStimulus(2, 3, 3);
        for (int k = 1; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst pulse", int'(pulse), 0);
        checkOutput("midrst busy", int'(busy), 0);
        checkOutput("midrst done", int'(done), 0);
        checkOutput("midrst cnt", int'(pulseCnt), 0);
        doneSeen = 0;
        for (int k = 0; k < 8; k++) begin
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
            tick();
        end
        checkOutput("midrst quiet", doneSeen, 0);
        runVector("after rst", base, -1, -1, 1'b0);

        // Widened instance: 15 pulses of 63 cycles with one-cycle gaps.
        hiLen2 = 6'd63;
        loLen2 = 6'd1;
        numIn2 = 4'd15;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        highs   = 0;
        doneCyc = -1;
        for (int k = 1; k <= 970; k++) begin
            if (pulse2 === 1'b1) highs++;
            if (done2 === 1'b1 && doneCyc < 0) begin
                doneCyc = k;
                checkOutput("wide cnt", int'(pulseCnt2), 15);
            end
            tick();
        end
        checkOutput("wide high cycles", highs, 945);
        checkOutput("wide done cycle", doneCyc, 960);
        checkOutput("wide idle busy", int'(busy2), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
